// File: rtl/zxuno_regbus_arbiter_pkg.sv
// Shared ZXUNO register-bus configuration: register addresses, arbiter state
// encodings and the aux timeout counter width.
package zxuno_regbus_arbiter_pkg;

    localparam logic [7:0] REG_MASTERCONF   = 8'h00;
    localparam logic [7:0] REG_MASTERMAPPER = 8'h01;
    localparam logic [7:0] REG_FLASHSPI     = 8'h02;
    localparam logic [7:0] REG_FLASHCS      = 8'h03;
    localparam logic [7:0] REG_SCANDBLCTRL  = 8'h0B;
    localparam logic [7:0] REG_RASTERLINE   = 8'h0C;
    localparam logic [7:0] REG_RASTERCTRL   = 8'h0D;
    localparam logic [7:0] REG_COREID       = 8'hFF;

    // Address shown on the shared bus when nobody is using it
    localparam logic [7:0] BUS_IDLE_ADDR = 8'h00;
    // Read value when no register block claims the access
    localparam logic [7:0] RDATA_NONE    = 8'hFF;

    localparam int AUX_TMO_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/zxuno_regbus_arbiter.sv
// Shares the ZXUNO register bus between the CPU (absolute priority, zero stall)
// and one auxiliary master that steals the first CPU-idle cycle.
module zxuno_regbus_arbiter
    import zxuno_regbus_arbiter_pkg::*;
#(
    parameter int AUX_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_regrd,
    input  logic       cpu_regwr,
    input  logic       aux_req,
    input  logic [7:0] aux_addr,
    input  logic       aux_wr,
    input  logic [7:0] aux_wdata,
    output logic       aux_busy,
    output logic       aux_done,
    output logic       aux_err,
    output logic [7:0] aux_rdata,
    output logic [7:0] zxuno_addr,
    output logic       zxuno_regrd,
    output logic       zxuno_regwr,
    output logic [7:0] aux_bus_din,
    input  logic [7:0] bus_dout,
    input  logic       bus_oe
);

    localparam logic [AUX_TMO_W-1:0] TMO_LAST = AUX_TMO_W'(AUX_TIMEOUT - 1);

    arb_state_t            state_reg, state_next;
    logic [AUX_TMO_W-1:0]  count_reg, count_next;
    logic [7:0]            addr_reg, addr_next;
    logic [7:0]            wdata_reg, wdata_next;
    logic [7:0]            rdata_reg, rdata_next;
    logic                  wr_reg, wr_next;
    logic                  err_reg, err_next;
    logic                  cpu_active;

    assign cpu_active = cpu_regrd | cpu_regwr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            rdata_reg <= RDATA_NONE;
            wr_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            wr_reg    <= wr_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        wr_next    = wr_reg;
        err_next   = err_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (aux_req) begin
                    addr_next  = aux_addr;
                    wr_next    = aux_wr;
                    wdata_next = aux_wdata;
                    count_next = '0;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (cpu_active) begin
                    count_next = count_reg + 1'b1;
                    if (count_reg == TMO_LAST) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end
                end else begin
                    // This is the cycle the aux strobe is on the bus
                    err_next = 1'b0;
                    if (!wr_reg)
                        rdata_next = bus_oe ? bus_dout : RDATA_NONE;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        zxuno_addr  = BUS_IDLE_ADDR;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        if (cpu_active) begin
            zxuno_addr  = cpu_addr;
            zxuno_regrd = cpu_regrd;
            zxuno_regwr = cpu_regwr;
        end else if (state_reg == ST_PEND) begin
            zxuno_addr  = addr_reg;
            zxuno_regrd = !wr_reg;
            zxuno_regwr = wr_reg;
        end
    end

    assign aux_busy    = (state_reg != ST_IDLE);
    assign aux_done    = (state_reg == ST_DONE);
    assign aux_err     = err_reg;
    assign aux_rdata   = rdata_reg;
    assign aux_bus_din = wdata_reg;

endmodule

// File: doc/zxuno_regbus_arbiter.md
ZXUNO_REGBUS_ARBITER -- requirements
Module: zxuno_regbus_arbiter

Interface
REQ-001 SHALL have parameter AUX_TIMEOUT, default 1023: number of PEND cycles lost to the CPU before an aux request aborts (range 1..1023).
REQ-002 SHALL have port clk, input, 1: system clock; the single clock domain.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port cpu_addr, input, 8: CPU-selected ZXUNO register address.
REQ-005 SHALL have port cpu_regrd, input, 1: CPU register read strobe (level).
REQ-006 SHALL have port cpu_regwr, input, 1: CPU register write strobe (level).
REQ-007 SHALL have port aux_req, input, 1: auxiliary master request, sampled only in IDLE.
REQ-008 SHALL have port aux_addr, input, 8: aux register address, captured with aux_req.
REQ-009 SHALL have port aux_wr, input, 1: 1 = write, 0 = read, captured with aux_req.
REQ-010 SHALL have port aux_wdata, input, 8: aux write data, captured with aux_req.
REQ-011 SHALL have port aux_busy, output, 1: high in PEND and DONE.
REQ-012 SHALL have port aux_done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port aux_err, output, 1: valid with aux_done; 1 = timed out, no access made.
REQ-014 SHALL have port aux_rdata, output, 8: read result, valid with aux_done, held until the next aux_done.
REQ-015 SHALL have port zxuno_addr, output, 8: shared register bus address.
REQ-016 SHALL have port zxuno_regrd, output, 1: shared bus read strobe.
REQ-017 SHALL have port zxuno_regwr, output, 1: shared bus write strobe.
REQ-018 SHALL have port aux_bus_din, output, 8: data driven to register blocks during aux writes.
REQ-019 SHALL have port bus_dout, input, 8: OR/mux of register-block read data.
REQ-020 SHALL have port bus_oe, input, 1: a register block claims the current read.

Function
REQ-021 CPU access SHALL always have priority: when cpu_regrd or cpu_regwr is high, zxuno_addr/regrd/regwr SHALL equal cpu_addr/cpu_regrd/cpu_regwr combinationally, with no stall.
REQ-022 FSM states SHALL be IDLE, PEND, DONE.
REQ-023 IDLE: on aux_req=1, SHALL latch aux_addr, aux_wr and aux_wdata, clear the wait counter and go to PEND the next cycle.
REQ-024 PEND, CPU idle in that cycle: SHALL drive the latched address with zxuno_regwr=aux_wr and zxuno_regrd=!aux_wr for exactly that one cycle, then go to DONE.
REQ-025 PEND, CPU active in that cycle: no aux strobe; the counter SHALL increment; at count = AUX_TIMEOUT the FSM SHALL go to DONE with the error flag set.
REQ-026 Aux read: at the PEND access cycle, aux_rdata SHALL capture bus_dout if bus_oe=1, else 8'hFF.
REQ-027 DONE: aux_done=1 for one cycle, then go to IDLE; aux_req high in DONE SHALL be ignored, and it is accepted in IDLE the following cycle.
REQ-028 Minimum latency: aux_req accepted at cycle n, bus strobe at n+1, aux_done at n+2.
REQ-029 When the bus is idle (no CPU or aux access), zxuno_regrd and zxuno_regwr SHALL be 0 and zxuno_addr SHALL be 8'h00.
REQ-030 aux_bus_din SHALL equal the latched aux_wdata at all times.
REQ-031 aux_req, aux_addr, aux_wr and aux_wdata changes during PEND/DONE SHALL have no effect.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, counter 0, aux_done 0, aux_err 0, aux_rdata 8'hFF, and latched addr/data 8'h00.
REQ-033 Reset mid-PEND SHALL abort the request with no aux_done pulse; CPU pass-through SHALL stay functional during reset.

Structure
REQ-034 State encodings and the aux timeout width (10 bits) SHALL live in the shared ZXUNO config include, next to the register address constants.
REQ-035 The block SHALL be a single module with no sub-modules; the CPU/aux bus mux is inline.

Verification
REQ-036 Idle CPU, aux write addr 8'h0E data 8'h5A -> regwr=1 addr 8'h0E at n+1, aux_done=1 err=0 at n+2.
REQ-037 Aux read addr 8'h0F, bus_oe=1, bus_dout 8'h13 -> aux_rdata=8'h13; repeat with bus_oe=0 -> aux_rdata=8'hFF.
REQ-038 CPU regwr held for 5 cycles after aux_req -> CPU addr passed through each cycle, aux strobe in the first CPU-idle cycle, done one cycle later.
REQ-039 AUX_TIMEOUT=4, CPU continuously active -> no aux strobe, aux_done=1 with aux_err=1 exactly 4 cycles after entering PEND.
REQ-040 rst_n asserted in PEND -> outputs at reset values immediately, no aux_done; a new aux_req after release completes normally.
